// File: rtl/tpm_locality_arbiter.sv
// TPM locality ownership arbiter with TIS access-register semantics.
// It tracks requestUse, seize and relinquish, and drains through a handoff window between owners.
module tpm_locality_arbiter #(
    parameter int unsigned NUM_LOC        = 5,
    parameter int unsigned HANDOFF_CYCLES = 4,
    parameter int unsigned CNT_W          = 4
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [NUM_LOC-1:0] req_use,
    input  logic [NUM_LOC-1:0] relinquish,
    input  logic [NUM_LOC-1:0] seize,
    input  logic [NUM_LOC-1:0] clr_seized,
    input  logic               spi_busy,
    output logic [2:0]         active_loc,
    output logic               active_valid,
    output logic [NUM_LOC-1:0] pending,
    output logic [NUM_LOC-1:0] been_seized,
    output logic               loc_change
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HANDOFF = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_active_loc, w_active_loc_nxt;
    logic [NUM_LOC-1:0] r_pending, w_pending_nxt;
    logic [NUM_LOC-1:0] r_been_seized, w_been_seized_nxt;
    logic               r_loc_change, w_loc_change_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [NUM_LOC-1:0] w_owner_mask, w_above_mask, w_seize_valid, w_idle_req;
    logic [NUM_LOC-1:0] w_pend_set, w_pend_clr, w_bs_set;
    logic [2:0]         w_grant_idx, w_seize_idx;
    logic               w_take;

    always_comb begin
        w_owner_mask = '0;
        w_above_mask = '0;
        for (int unsigned i = 0; i < NUM_LOC; i++) begin
            w_above_mask[i] = (i > 32'(r_active_loc));
            w_owner_mask[i] = (r_state == ST_ACTIVE) && (i == 32'(r_active_loc));
        end
    end

    // An IDLE grant also considers requests arriving this cycle, so one edge suffices.
    assign w_idle_req    = (r_pending | req_use | seize) & ~relinquish;
    assign w_seize_valid = (r_state == ST_ACTIVE) ? (seize & w_above_mask) : '0;

    always_comb begin
        w_grant_idx = '0;
        w_seize_idx = '0;
        for (int unsigned i = 0; i < NUM_LOC; i++) begin
            if (w_idle_req[i])    w_grant_idx = 3'(i);
            if (w_seize_valid[i]) w_seize_idx = 3'(i);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_active_loc_nxt = r_active_loc;
        w_cnt_nxt        = r_cnt;
        w_loc_change_nxt = 1'b0;
        w_take           = 1'b0;
        w_bs_set         = '0;
        w_pend_set       = req_use & ~w_owner_mask;
        if (r_state != ST_ACTIVE) w_pend_set = w_pend_set | seize;
        w_pend_clr       = relinquish & ~w_owner_mask;

        case (r_state)
            ST_IDLE: begin
                if ((|w_idle_req) && !spi_busy) begin
                    w_state_nxt      = ST_ACTIVE;
                    w_active_loc_nxt = w_grant_idx;
                    w_loc_change_nxt = 1'b1;
                    w_take           = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // A valid seize outranks the owner's own relinquish in the same cycle.
                if (|w_seize_valid) begin
                    w_active_loc_nxt = w_seize_idx;
                    w_loc_change_nxt = 1'b1;
                    w_bs_set         = w_owner_mask;
                    w_take           = 1'b1;
                end else if (|(relinquish & w_owner_mask)) begin
                    w_state_nxt      = ST_HANDOFF;
                    w_active_loc_nxt = '0;
                    w_cnt_nxt        = CNT_W'(HANDOFF_CYCLES);
                end
            end
            ST_HANDOFF: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!spi_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        for (int unsigned i = 0; i < NUM_LOC; i++) begin
            if (w_take && (32'(w_active_loc_nxt) == i)) w_pend_clr[i] = 1'b1;
        end
        w_pending_nxt     = (r_pending | w_pend_set) & ~w_pend_clr;
        w_been_seized_nxt = (r_been_seized & ~clr_seized) | w_bs_set;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_active_loc  <= '0;
            r_pending     <= '0;
            r_been_seized <= '0;
            r_loc_change  <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_active_loc  <= w_active_loc_nxt;
            r_pending     <= w_pending_nxt;
            r_been_seized <= w_been_seized_nxt;
            r_loc_change  <= w_loc_change_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign active_loc   = r_active_loc;
    assign active_valid = (r_state == ST_ACTIVE);
    assign pending      = r_pending;
    assign been_seized  = r_been_seized;
    assign loc_change   = r_loc_change;

endmodule

// File: tb/tb_tpm_locality_arbiter.sv
// Bench for tpm_locality_arbiter: two builds (4 and 0 handoff cycles) share stimulus
// and are compared against a locality-ownership model plus directed expectations.
module tb_tpm_locality_arbiter;

    localparam int NL = 5;
    localparam logic [4:0] Z = 5'b00000;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b0;
    logic [4:0] req_use = '0, relinquish = '0, seize = '0, clr_seized = '0;
    logic       spi_busy = 1'b0;

    logic [2:0] active_loc0, active_loc1;
    logic       active_valid0, active_valid1, loc_change0, loc_change1;
    logic [4:0] pending0, pending1, been_seized0, been_seized1;
    logic [14:0] st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner -1 means nobody owns; ho -1 means not draining, else cycles left.
    int         m_owner[2];
    int         m_ho[2];
    logic [4:0] m_pend[2];
    logic [4:0] m_bs[2];
    logic       m_chg[2];
    int         m_h[2] = '{4, 0};

    always #5 CLOCK_50 = ~CLOCK_50;

    tpm_locality_arbiter #(.NUM_LOC(5), .HANDOFF_CYCLES(4), .CNT_W(4)) u_dut_h4 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .req_use(req_use), .relinquish(relinquish),
        .seize(seize), .clr_seized(clr_seized), .spi_busy(spi_busy),
        .active_loc(active_loc0), .active_valid(active_valid0), .pending(pending0),
        .been_seized(been_seized0), .loc_change(loc_change0));

    tpm_locality_arbiter #(.NUM_LOC(5), .HANDOFF_CYCLES(0), .CNT_W(4)) u_dut_h0 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .req_use(req_use), .relinquish(relinquish),
        .seize(seize), .clr_seized(clr_seized), .spi_busy(spi_busy),
        .active_loc(active_loc1), .active_valid(active_valid1), .pending(pending1),
        .been_seized(been_seized1), .loc_change(loc_change1));

    assign st0 = {active_valid0, active_loc0, pending0, been_seized0, loc_change0};
    assign st1 = {active_valid1, active_loc1, pending1, been_seized1, loc_change1};

    function automatic logic [14:0] exp_st(int k);
        logic [2:0] loc;
        loc = (m_owner[k] >= 0) ? 3'(m_owner[k]) : 3'd0;
        return {m_owner[k] >= 0, loc, m_pend[k], m_bs[k], m_chg[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_ho[k]    = -1;
            m_pend[k]  = '0;
            m_bs[k]    = '0;
            m_chg[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [4:0] ru, rl, sz, cs, input logic busy);
        for (int k = 0; k < 2; k++) begin
            int         own;
            int         best;
            logic [4:0] np;
            logic [4:0] nb;
            own  = m_owner[k];
            best = -1;
            np   = m_pend[k];
            for (int i = 0; i < NL; i++) begin
                if (ru[i] && i != own) np[i] = 1'b1;
                if (sz[i] && own < 0)  np[i] = 1'b1;
                if (rl[i] && i != own) np[i] = 1'b0;
            end
            nb = m_bs[k] & ~cs;
            m_chg[k] = 1'b0;
            if (own < 0 && m_ho[k] < 0) begin
                if (!busy)
                    for (int i = 0; i < NL; i++)
                        if ((m_pend[k][i] || ru[i] || sz[i]) && !rl[i]) best = i;
                if (best >= 0) begin
                    m_owner[k] = best;
                    np[best]   = 1'b0;
                    m_chg[k]   = 1'b1;
                end
            end else if (own >= 0) begin
                for (int j = own + 1; j < NL; j++) if (sz[j]) best = j;
                if (best >= 0) begin
                    nb[own]    = 1'b1;
                    m_owner[k] = best;
                    np[best]   = 1'b0;
                    m_chg[k]   = 1'b1;
                end else if (rl[own]) begin
                    m_owner[k] = -1;
                    m_ho[k]    = m_h[k];
                end
            end else begin
                if (m_ho[k] == 0) begin
                    if (!busy) m_ho[k] = -1;
                end else begin
                    m_ho[k] = m_ho[k] - 1;
                end
            end
            m_pend[k] = np;
            m_bs[k]   = nb;
        end
    endtask

    task automatic tick(input logic [4:0] ru, rl, sz, cs, input logic busy);
        req_use = ru; relinquish = rl; seize = sz; clr_seized = cs; spi_busy = busy;
        @(posedge CLOCK_50);
        model_step(ru, rl, sz, cs, busy);
        #1;
        req_use = '0; relinquish = '0; seize = '0; clr_seized = '0; spi_busy = 1'b0;
    endtask

    task automatic test_reset();
        #1 RESET = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (st0 !== 15'd0) begin n_fail++; $display("FAIL reset_h4: got %h expected %h", st0, 15'd0); end
        n_checks++;
        if (st1 !== 15'd0) begin n_fail++; $display("FAIL reset_h0: got %h expected %h", st1, 15'd0); end
        req_use = 5'b10001;
        @(posedge CLOCK_50);
        #1;
        req_use = '0;
        n_checks++;
        if (st0 !== 15'd0) begin n_fail++; $display("FAIL reset_held: got %h expected %h", st0, 15'd0); end
        RESET = 1'b0;
    endtask

    task automatic test_first_grant();
        tick(Z, Z, Z, Z, 1'b0);
        tick(Z, Z, Z, Z, 1'b0);
        tick(5'b00001, Z, Z, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_loc0, loc_change0} !== 5'b1_000_1) begin
            n_fail++; $display("FAIL first_grant_h4: got %b expected %b", {active_valid0, active_loc0, loc_change0}, 5'b1_000_1);
        end
        n_checks++;
        if ({active_valid1, active_loc1, loc_change1} !== 5'b1_000_1) begin
            n_fail++; $display("FAIL first_grant_h0: got %b expected %b", {active_valid1, active_loc1, loc_change1}, 5'b1_000_1);
        end
        tick(Z, Z, Z, Z, 1'b0);
        n_checks++;
        if (loc_change0 !== 1'b0) begin n_fail++; $display("FAIL first_grant_pulse: got %b expected 0", loc_change0); end
    endtask

    task automatic test_handoff_grant();
        int n;
        tick(5'b01010, Z, Z, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_loc0, pending0} !== {1'b1, 3'd0, 5'b01010}) begin
            n_fail++; $display("FAIL handoff_pending: got %b expected %b", {active_valid0, active_loc0, pending0}, {1'b1, 3'd0, 5'b01010});
        end
        tick(Z, 5'b00001, Z, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_loc0, loc_change0} !== 5'b0) begin
            n_fail++; $display("FAIL handoff_enter: got %b expected %b", {active_valid0, active_loc0, loc_change0}, 5'b0);
        end
        n = 0;
        do begin
            tick(Z, Z, Z, Z, 1'b0);
            n++;
        end while (!active_valid0 && n < 20);
        n_checks++;
        if (n !== 6) begin n_fail++; $display("FAIL handoff_latency: got %0d expected %0d", n, 6); end
        n_checks++;
        if ({active_loc0, pending0, loc_change0} !== {3'd3, 5'b00010, 1'b1}) begin
            n_fail++; $display("FAIL handoff_grant: got %b expected %b", {active_loc0, pending0, loc_change0}, {3'd3, 5'b00010, 1'b1});
        end
        n_checks++;
        if (st1 !== exp_st(1)) begin n_fail++; $display("FAIL handoff_model_h0: got %h expected %h", st1, exp_st(1)); end
        tick(Z, Z, Z, Z, 1'b0);
        n_checks++;
        if (loc_change0 !== 1'b0) begin n_fail++; $display("FAIL handoff_pulse: got %b expected 0", loc_change0); end
    endtask

    task automatic test_seize();
        int n;
        tick(Z, 5'b01000, Z, Z, 1'b0);
        n = 0;
        do begin
            tick(Z, Z, Z, Z, 1'b0);
            n++;
        end while (!active_valid0 && n < 20);
        n_checks++;
        if ({active_valid0, active_loc0, active_valid1, active_loc1} !== {1'b1, 3'd1, 1'b1, 3'd1}) begin
            n_fail++; $display("FAIL seize_owner1: got %b expected %b", {active_valid0, active_loc0, active_valid1, active_loc1}, {1'b1, 3'd1, 1'b1, 3'd1});
        end
        tick(Z, Z, 5'b10100, Z, 1'b0);
        n_checks++;
        if ({active_loc0, been_seized0, loc_change0} !== {3'd4, 5'b00010, 1'b1}) begin
            n_fail++; $display("FAIL seize_multi: got %b expected %b", {active_loc0, been_seized0, loc_change0}, {3'd4, 5'b00010, 1'b1});
        end
        tick(Z, Z, Z, 5'b00010, 1'b0);
        n_checks++;
        if (been_seized0 !== 5'b0) begin n_fail++; $display("FAIL seize_clear: got %b expected %b", been_seized0, 5'b0); end
        tick(Z, Z, 5'b00001, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_loc0, loc_change0, been_seized0} !== {1'b1, 3'd4, 1'b0, 5'b0}) begin
            n_fail++; $display("FAIL seize_lower: got %b expected %b", {active_valid0, active_loc0, loc_change0, been_seized0}, {1'b1, 3'd4, 1'b0, 5'b0});
        end
        n_checks++;
        if (st1 !== exp_st(1)) begin n_fail++; $display("FAIL seize_model_h0: got %h expected %h", st1, exp_st(1)); end
    endtask

    task automatic test_busy();
        tick(Z, 5'b10000, Z, Z, 1'b0);
        for (int i = 0; i < 8; i++) tick(Z, Z, Z, Z, 1'b0);
        tick(5'b00100, Z, Z, Z, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(Z, Z, Z, Z, 1'b1);
            n_checks++;
            if ({active_valid0, active_valid1} !== 2'b00) begin
                n_fail++; $display("FAIL busy_hold[%0d]: got %b expected %b", i, {active_valid0, active_valid1}, 2'b00);
            end
        end
        n_checks++;
        if (pending0 !== 5'b00100) begin n_fail++; $display("FAIL busy_pending: got %b expected %b", pending0, 5'b00100); end
        tick(Z, Z, Z, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_loc0, loc_change0, active_valid1, active_loc1} !== {1'b1, 3'd2, 1'b1, 1'b1, 3'd2}) begin
            n_fail++; $display("FAIL busy_release: got %b expected %b", {active_valid0, active_loc0, loc_change0, active_valid1, active_loc1}, {1'b1, 3'd2, 1'b1, 1'b1, 3'd2});
        end
    endtask

    task automatic test_seize_relinquish();
        tick(Z, 5'b00100, 5'b01000, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_loc0, been_seized0, loc_change0} !== {1'b1, 3'd3, 5'b00100, 1'b1}) begin
            n_fail++; $display("FAIL seize_vs_rel: got %b expected %b", {active_valid0, active_loc0, been_seized0, loc_change0}, {1'b1, 3'd3, 5'b00100, 1'b1});
        end
        tick(Z, Z, Z, Z, 1'b0);
        n_checks++;
        if ({active_valid0, active_valid1} !== 2'b11) begin
            n_fail++; $display("FAIL seize_vs_rel_no_handoff: got %b expected %b", {active_valid0, active_valid1}, 2'b11);
        end
        tick(5'b00010, 5'b00010, Z, Z, 1'b0);
        n_checks++;
        if ({pending0, pending1} !== 10'b0) begin
            n_fail++; $display("FAIL req_rel_same: got %b expected %b", {pending0, pending1}, 10'b0);
        end
    endtask

    task automatic test_random();
        logic [4:0] ru, rl, sz, cs;
        logic       busy;
        for (int t = 0; t < 600; t++) begin
            ru   = ($urandom_range(0, 2) == 0) ? 5'($urandom) & 5'($urandom) : 5'd0;
            rl   = ($urandom_range(0, 3) == 0) ? 5'($urandom) & 5'($urandom) : 5'd0;
            sz   = ($urandom_range(0, 5) == 0) ? 5'($urandom) & 5'($urandom) : 5'd0;
            cs   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            busy = ($urandom_range(0, 3) == 0);
            tick(ru, rl, sz, cs, busy);
            n_checks++;
            if (st0 !== exp_st(0)) begin n_fail++; $display("FAIL random_h4[%0d]: got %h expected %h", t, st0, exp_st(0)); end
            n_checks++;
            if (st1 !== exp_st(1)) begin n_fail++; $display("FAIL random_h0[%0d]: got %h expected %h", t, st1, exp_st(1)); end
        end
    endtask

    task automatic test_reset_midhandoff();
        int n;
        RESET = 1'b1;
        model_reset();
        @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        tick(5'b00001, Z, Z, Z, 1'b0);
        tick(Z, 5'b00001, Z, Z, 1'b0);
        tick(5'b00100, Z, Z, Z, 1'b0);
        tick(Z, Z, Z, Z, 1'b0);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (st0 !== 15'd0) begin n_fail++; $display("FAIL midhandoff_reset_h4: got %h expected %h", st0, 15'd0); end
        n_checks++;
        if (st1 !== 15'd0) begin n_fail++; $display("FAIL midhandoff_reset_h0: got %h expected %h", st1, 15'd0); end
        @(posedge CLOCK_50);
        #1 RESET = 1'b0;
        tick(5'b00001, Z, Z, Z, 1'b0);
        tick(5'b01000, Z, Z, Z, 1'b0);
        tick(Z, 5'b00001, Z, Z, 1'b0);
        n = 0;
        do begin
            tick(Z, Z, Z, Z, 1'b0);
            n++;
        end while (!active_valid1 && n < 20);
        n_checks++;
        if (n !== 2) begin n_fail++; $display("FAIL zero_handoff_latency: got %0d expected %0d", n, 2); end
        n_checks++;
        if ({active_loc1, loc_change1} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL zero_handoff_grant: got %b expected %b", {active_loc1, loc_change1}, {3'd3, 1'b1});
        end
        n_checks++;
        if (st0 !== exp_st(0)) begin n_fail++; $display("FAIL zero_handoff_model_h4: got %h expected %h", st0, exp_st(0)); end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_grant();
        test_handoff_grant();
        test_seize();
        test_busy();
        test_seize_relinquish();
        test_random();
        test_reset_midhandoff();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
